// File: rtl/cfu_wb_buffer_if.sv
// Writeback port bundle between cfu_wb_buffer (master) and the shared writeback arbiter (slave).
interface cfu_wb_buffer_if #(
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 4
);
  logic                     valid;
  logic [XLEN-1:0]          result;
  logic [TRANS_ID_BITS-1:0] trans_id;
  logic                     ack;

  modport master (output valid, output result, output trans_id, input ack);
  modport slave  (input valid, input result, input trans_id, output ack);
endinterface

// File: rtl/cfu_wb_buffer.sv
// Result buffer between the fixed-latency dot-product FU and the shared writeback port.
// Optional same-cycle bypass when the FIFO is empty: define CFU_WB_BYPASS_EN.
module cfu_wb_buffer #(
  parameter int DEPTH         = 4,
  parameter int XLEN          = 32,
  parameter int TRANS_ID_BITS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         issue_valid_i,
  output logic                         issue_ready_o,
  input  logic                         fu_valid_i,
  input  logic [XLEN-1:0]              fu_result_i,
  input  logic [TRANS_ID_BITS-1:0]     fu_trans_id_i,
  cfu_wb_buffer_if.master              wb,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         protocol_err_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  // Handshakes: an issue is taken when issue_valid_i && issue_ready_o; the head entry
  // leaves when wb.valid && wb.ack. Neither side may withdraw on its own; flush_i overrides both.

  logic [XLEN-1:0]          res_mem_q [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem_q  [DEPTH];
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d, inflight_q, inflight_d;
  logic                     err_q, err_d;

  logic full, empty, fu_take, pop, push, bypass, bypass_done;
  logic issue_fire, inflight_dec, overflow, underflow;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign fu_take      = fu_valid_i && !flush_i;
`ifdef CFU_WB_BYPASS_EN
  assign bypass       = empty && fu_take;
`else
  assign bypass       = 1'b0;
`endif
  assign bypass_done  = bypass && wb.ack;
  assign pop          = !empty && wb.ack && !flush_i;
  assign push         = fu_take && !bypass_done && (!full || pop);
  assign overflow     = fu_take && full && !pop;
  assign underflow    = fu_take && (inflight_q == '0);
  assign issue_fire   = issue_valid_i && issue_ready_o && !flush_i;
  assign inflight_dec = fu_take && (inflight_q != '0);

  // Ready reserves a slot for every op still inside the FU, so it depends only on registers.
  assign issue_ready_o  = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  assign occupancy_o    = count_q;
  assign protocol_err_o = err_q;

  assign wb.valid    = !empty || bypass;
  assign wb.result   = bypass ? fu_result_i   : res_mem_q[rd_ptr_q];
  assign wb.trans_id = bypass ? fu_trans_id_i : id_mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q || overflow || underflow;
    if (flush_i) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case ({issue_fire, inflight_dec})
        2'b10:   inflight_d = inflight_q + CW'(1);
        2'b01:   inflight_d = inflight_q - CW'(1);
        default: inflight_d = inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem_q[wr_ptr_q] <= fu_result_i;
      id_mem_q[wr_ptr_q]  <= fu_trans_id_i;
    end
  end
endmodule
